// File: rtl/reg_check_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_check_pkg
//  Description : Shared FSM state encoding and default parameter values for
//                the register-file result checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_check_pkg;

    localparam int c_dw_default      = 8;
    localparam int c_aw_default      = 3;
    localparam int c_nchk_default    = 4;
    localparam int c_timeout_default = 255;
    localparam int c_req_len_default = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : wait_timer
//  Description : Counts enabled cycles; expired is high on the LIMIT-th
//                consecutive enabled cycle since the last clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module wait_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int c_cw = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [c_cw-1:0] r_count;

    // Cycle counter: cleared outside the wait window, saturates at LIMIT-1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + c_cw'(1);
        end
    end

    assign expired = enable && (r_count == c_cw'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/reg_check_seq.sv
`default_nettype none
// ============================================================================
//  Module      : reg_check_seq
//  Description : Kicks a processor under test, waits for completion (with a
//                timeout), then walks a set of expected register values
//                through the register-file read port and reports the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_check_seq
    import reg_check_pkg::*;
#(
    parameter int DW      = c_dw_default,
    parameter int AW      = c_aw_default,
    parameter int NCHK    = c_nchk_default,
    parameter int TIMEOUT = c_timeout_default,
    parameter int REQ_LEN = c_req_len_default
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NCHK-1:0]             exp_en,
    input  logic [NCHK*AW-1:0]          exp_addr,
    input  logic [NCHK*DW-1:0]          exp_data,
    output logic                        dut_req,
    input  logic                        dut_done,
    output logic [AW-1:0]               rd_addr,
    input  logic [DW-1:0]               rd_data,
    output logic                        busy,
    output logic                        finished,
    output logic                        pass,
    output logic                        timed_out,
    output logic [$clog2(NCHK+1)-1:0]   err_count,
    output logic [$clog2(NCHK)-1:0]     fail_idx,
    output logic [DW-1:0]               fail_data
);

    localparam int c_sw = $clog2(NCHK);
    localparam int c_ew = $clog2(NCHK + 1);
    localparam int c_rw = (REQ_LEN > 1) ? $clog2(REQ_LEN + 1) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_rw-1:0]    r_req_cnt;
    logic               r_done_seen;
    logic [c_sw-1:0]    r_slot;
    logic               r_pass;
    logic               r_timed_out;
    logic [c_ew-1:0]    r_err_count;
    logic [c_sw-1:0]    r_fail_idx;
    logic [DW-1:0]      r_fail_data;

    logic               w_accept;
    logic               w_req_last;
    logic               w_slot_last;
    logic               w_expired;
    logic               w_timeout_hit;
    logic [AW-1:0]      w_slot_addr;
    logic [DW-1:0]      w_slot_data;
    logic               w_mismatch;
    logic [c_ew-1:0]    w_err_nxt;

    assign w_req_last  = (r_req_cnt == c_rw'(REQ_LEN - 1));
    assign w_slot_last = (r_slot == c_sw'(NCHK - 1));
    assign w_slot_addr = exp_addr[int'(r_slot)*AW +: AW];
    assign w_slot_data = exp_data[int'(r_slot)*DW +: DW];
    assign w_mismatch  = (r_state == ST_CHECK) && exp_en[r_slot] && (rd_data != w_slot_data);
    assign w_err_nxt   = r_err_count + c_ew'(w_mismatch);
    // Completion in the last waiting cycle still counts as on time
    assign w_timeout_hit = (r_state == ST_WAIT) && !dut_done && w_expired;

    wait_timer #(
        .LIMIT   (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (r_state != ST_WAIT),
        .enable  (r_state == ST_WAIT),
        .expired (w_expired)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and start acceptance
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_req_last) begin
                    w_state_nxt = (r_done_seen || dut_done) ? ST_CHECK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dut_done) begin
                    w_state_nxt = ST_CHECK;
                end else if (w_expired) begin
                    w_state_nxt = ST_REPORT;
                end
            end
            ST_CHECK: begin
                if (w_slot_last) begin
                    w_state_nxt = ST_REPORT;
                end
            end
            ST_REPORT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sequencing counters: request length, early-done latch, slot walk
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req_cnt   <= '0;
            r_done_seen <= 1'b0;
            r_slot      <= '0;
        end else begin
            r_req_cnt   <= (r_state == ST_REQ) ? (r_req_cnt + c_rw'(1)) : '0;
            r_done_seen <= (r_state == ST_REQ) && (r_done_seen || dut_done);
            r_slot      <= ((r_state == ST_CHECK) && !w_slot_last) ? (r_slot + c_sw'(1)) : '0;
        end
    end

    // Result registers: cleared on acceptance, updated by checks/timeout, held otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pass      <= 1'b0;
            r_timed_out <= 1'b0;
            r_err_count <= '0;
            r_fail_idx  <= '0;
            r_fail_data <= '0;
        end else if (w_accept) begin
            r_pass      <= 1'b0;
            r_timed_out <= 1'b0;
            r_err_count <= '0;
            r_fail_idx  <= '0;
            r_fail_data <= '0;
        end else begin
            if (w_timeout_hit) begin
                r_timed_out <= 1'b1;
                r_pass      <= 1'b0;
            end
            if (w_mismatch) begin
                r_err_count <= w_err_nxt;
                // Only the lowest-index mismatch is recorded
                if (r_err_count == '0) begin
                    r_fail_idx  <= r_slot;
                    r_fail_data <= rd_data;
                end
            end
            // Verdict is settled on the final slot so it is valid during REPORT
            if ((r_state == ST_CHECK) && w_slot_last) begin
                r_pass <= (w_err_nxt == '0);
            end
        end
    end

    assign dut_req   = (r_state == ST_REQ);
    assign finished  = (r_state == ST_REPORT);
    // The acceptance cycle itself counts as busy; gated so reset forces it low
    assign busy      = reset && ((r_state != ST_IDLE) || start);
    assign rd_addr   = (r_state == ST_CHECK) ? w_slot_addr : '0;
    assign pass      = r_pass;
    assign timed_out = r_timed_out;
    assign err_count = r_err_count;
    assign fail_idx  = r_fail_idx;
    assign fail_data = r_fail_data;

endmodule
`default_nettype wire

// File: tb/tb_reg_check_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_check_seq
//  Description : Directed, table-driven bench for reg_check_seq with a small
//                register-file model (DW=5, AW=3, NCHK=4, TIMEOUT=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_check_seq;

    localparam int DW = 5;
    localparam int AW = 3;
    localparam int NCHK = 4;

    typedef struct {
        int          s;        // 0: REQ_LEN=1 instance, 1: REQ_LEN=2 instance
        logic [3:0]  en;
        logic [11:0] addr;
        logic [19:0] data;
        logic [39:0] core;     // {core7 .. core0}
        int          delay;    // cycles from first dut_req to dut_done, -1 = never
        int          restart;  // cycle of an extra start pulse, -1 = none
        int          pass_e;
        int          to_e;
        int          err_e;
        int          fidx_e;
        int          fdata_e;
        int          busy_e;
        int          chk_e;
        int          req_e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_v;
    logic        done_v;
    int          sel;
    logic [3:0]  exp_en;
    logic [11:0] exp_addr;
    logic [19:0] exp_data;
    logic [39:0] core;

    logic req1, busy1, fin1, pass1, to1;
    logic [2:0] err1, rda1;
    logic [1:0] fidx1;
    logic [4:0] fdata1, rdd1;
    logic req2, busy2, fin2, pass2, to2;
    logic [2:0] err2, rda2;
    logic [1:0] fidx2;
    logic [4:0] fdata2, rdd2;

    assign rdd1 = core[int'(rda1)*DW +: DW];
    assign rdd2 = core[int'(rda2)*DW +: DW];

    reg_check_seq #(.DW(DW), .AW(AW), .NCHK(NCHK), .TIMEOUT(16), .REQ_LEN(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_v && sel == 0),
        .exp_en(exp_en), .exp_addr(exp_addr), .exp_data(exp_data),
        .dut_req(req1), .dut_done(done_v && sel == 0),
        .rd_addr(rda1), .rd_data(rdd1),
        .busy(busy1), .finished(fin1), .pass(pass1), .timed_out(to1),
        .err_count(err1), .fail_idx(fidx1), .fail_data(fdata1)
    );

    reg_check_seq #(.DW(DW), .AW(AW), .NCHK(NCHK), .TIMEOUT(16), .REQ_LEN(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start_v && sel == 1),
        .exp_en(exp_en), .exp_addr(exp_addr), .exp_data(exp_data),
        .dut_req(req2), .dut_done(done_v && sel == 1),
        .rd_addr(rda2), .rd_data(rdd2),
        .busy(busy2), .finished(fin2), .pass(pass2), .timed_out(to2),
        .err_count(err2), .fail_idx(fidx2), .fail_data(fdata2)
    );

    // Observed outputs of the instance currently under test
    logic req_o, busy_o, fin_o, pass_o, to_o;
    logic [2:0] err_o, rda_o;
    logic [1:0] fidx_o;
    logic [4:0] fdata_o;
    always_comb begin
        req_o = req1; busy_o = busy1; fin_o = fin1; pass_o = pass1; to_o = to1;
        err_o = err1; rda_o = rda1; fidx_o = fidx1; fdata_o = fdata1;
        if (sel == 1) begin
            req_o = req2; busy_o = busy2; fin_o = fin2; pass_o = pass2; to_o = to2;
            err_o = err2; rda_o = rda2; fidx_o = fidx2; fdata_o = fdata2;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, " dut_req"},   32'(req_o),   0);
        chk({tag, " busy"},      32'(busy_o),  0);
        chk({tag, " finished"},  32'(fin_o),   0);
        chk({tag, " pass"},      32'(pass_o),  0);
        chk({tag, " timed_out"}, 32'(to_o),    0);
        chk({tag, " err_count"}, 32'(err_o),   0);
        chk({tag, " fail_idx"},  32'(fidx_o),  0);
        chk({tag, " fail_data"}, 32'(fdata_o), 0);
        chk({tag, " rd_addr"},   32'(rda_o),   0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   req_cyc;
        int   busy_n;
        int   chk_n;
        int   fin_n;
        int   req_n;
        logic pass_f;
        sel      = v.s;
        exp_en   = v.en;
        exp_addr = v.addr;
        exp_data = v.data;
        core     = v.core;
        req_cyc = -1; busy_n = 0; chk_n = 0; fin_n = 0; req_n = 0; pass_f = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            start_v = (c == 0) || (c == v.restart);
            if (req_o === 1'b1) begin
                req_n++;
                if (req_cyc < 0) req_cyc = c;
            end
            done_v = (v.delay >= 0) && (req_cyc >= 0) && (c == req_cyc + v.delay);
            #1;
            if (busy_o === 1'b1) busy_n++;
            if (rda_o !== 3'd0) chk_n++;
            if (fin_o === 1'b1) begin
                fin_n++;
                pass_f = pass_o;
            end
        end
        start_v = 1'b0;
        done_v  = 1'b0;
        chk({tag, " finished pulses"}, 32'(fin_n), 1);
        chk({tag, " busy cycles"},     32'(busy_n), 32'(v.busy_e));
        chk({tag, " check cycles"},    32'(chk_n), 32'(v.chk_e));
        chk({tag, " dut_req cycles"},  32'(req_n), 32'(v.req_e));
        chk({tag, " pass@finished"},   32'(pass_f), 32'(v.pass_e));
        chk({tag, " pass held"},       32'(pass_o), 32'(v.pass_e));
        chk({tag, " timed_out"},       32'(to_o), 32'(v.to_e));
        chk({tag, " err_count"},       32'(err_o), 32'(v.err_e));
        chk({tag, " fail_idx"},        32'(fidx_o), 32'(v.fidx_e));
        chk({tag, " fail_data"},       32'(fdata_o), 32'(v.fdata_e));
    endtask

    vec_t vecs[8];

    initial begin
        int fin_n;
        int busy_n;

        // s, en, addr, data, core, delay, restart, pass, to, err, fidx, fdata, busy, chk, req
        vecs[0] = '{0, 4'b0001, {3'd7, 3'd6, 3'd5, 3'd1}, {5'd0, 5'd0, 5'd0, 5'd3},
                    {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0},
                    3, -1, 1, 0, 0, 0, 0, 10, 4, 1};
        vecs[1] = '{0, 4'b1100, {3'd4, 3'd2, 3'd3, 3'd1}, {5'd9, 5'd7, 5'd0, 5'd0},
                    {5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd6, 5'd0, 5'd0},
                    3, 6, 0, 0, 2, 2, 6, 10, 4, 1};
        vecs[2] = '{0, 4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 20'd0, 40'd0,
                    -1, -1, 0, 1, 0, 0, 0, 19, 0, 1};
        vecs[3] = '{0, 4'b0000, {3'd4, 3'd3, 3'd2, 3'd1}, {5'd1, 5'd2, 5'd3, 5'd4}, 40'd0,
                    3, -1, 1, 0, 0, 0, 0, 10, 4, 1};
        vecs[4] = '{0, 4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, {5'd0, 5'd31, 5'd17, 5'd9},
                    {5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd17, 5'd9, 5'd0},
                    0, 3, 1, 0, 0, 0, 0, 7, 4, 1};
        vecs[5] = '{0, 4'b1111, {3'd5, 3'd3, 3'd2, 3'd1}, {5'd30, 5'd0, 5'd11, 5'd5},
                    {5'd0, 5'd0, 5'd31, 5'd0, 5'd0, 5'd10, 5'd5, 5'd0},
                    16, -1, 0, 0, 2, 1, 10, 23, 4, 1};
        vecs[6] = '{0, 4'b1111, {3'd5, 3'd3, 3'd2, 3'd1}, {5'd30, 5'd0, 5'd11, 5'd5},
                    {5'd0, 5'd0, 5'd31, 5'd0, 5'd0, 5'd10, 5'd5, 5'd0},
                    17, -1, 0, 1, 0, 0, 0, 19, 0, 1};
        vecs[7] = '{1, 4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, {5'd0, 5'd31, 5'd17, 5'd9},
                    {5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd17, 5'd9, 5'd0},
                    1, 3, 1, 0, 0, 0, 0, 8, 4, 2};

        reset    = 1'b0;
        start_v  = 1'b0;
        done_v   = 1'b0;
        sel      = 0;
        exp_en   = '0;
        exp_addr = '0;
        exp_data = '0;
        core     = '0;

        // Outputs while held in reset, then just after release
        repeat (3) @(negedge clk);
        #1 check_idle_zero("in reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1 check_idle_zero("after reset");

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Asynchronous clear of held results (last dut1 run timed out)
        sel = 0;
        @(negedge clk);
        #1 chk("rstA timed_out before", 32'(to_o), 1);
        #2 reset = 1'b0;
        #1 check_idle_zero("rstA");
        @(negedge clk);
        reset = 1'b1;

        // Reset mid-WAIT aborts the run without a finished pulse
        exp_en   = vecs[0].en;
        exp_addr = vecs[0].addr;
        exp_data = vecs[0].data;
        core     = vecs[0].core;
        @(negedge clk);
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        #1 chk("rstB dut_req in REQ", 32'(req_o), 1);
        @(negedge clk);
        @(negedge clk);
        #1 chk("rstB busy in WAIT", 32'(busy_o), 1);
        #2 reset = 1'b0;
        #1 check_idle_zero("rstB");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        fin_n = 0;
        busy_n = 0;
        repeat (25) begin
            @(negedge clk);
            #1;
            if (fin_o === 1'b1) fin_n++;
            if (busy_o === 1'b1) busy_n++;
        end
        chk("rstB finished after abort", 32'(fin_n), 0);
        chk("rstB busy after abort", 32'(busy_n), 0);
        run_vec(vecs[0], "rerun v0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
